// File: rtl/wddl_prech_reg.sv
// Dual-rail WDDL pipeline register with an enforced precharge/evaluate cycle.
// Invalid codewords (p==n) are squashed to (0,0) at capture and reported through sticky/counted status.

module wddl_lane (
  input  logic clk,
  input  logic rst,
  input  logic cap,
  input  logic clr,
  input  logic p_in,
  input  logic n_in,
  output logic p_out,
  output logic n_out,
  output logic inv
);
  assign inv = ~(p_in ^ n_in);

  // Masking each rail with the complement of the other turns both 00 and 11 into 00.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_out <= 1'b0;
      n_out <= 1'b0;
    end else if (cap) begin
      p_out <= p_in & ~n_in;
      n_out <= n_in & ~p_in;
    end else if (clr) begin
      p_out <= 1'b0;
      n_out <= 1'b0;
    end
  end
endmodule

module wddl_prech_reg #(
  parameter int WIDTH      = 1,
  parameter int PRE_CYCLES = 1,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     d_p_in,
  input  logic [WIDTH-1:0]     d_n_in,
  output logic [WIDTH-1:0]     d_p_out,
  output logic [WIDTH-1:0]     d_n_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 err_clr,
  output logic                 err_flag,
  output logic [ERR_CNT_W-1:0] err_count
);
  localparam int PCW = (PRE_CYCLES > 1) ? $clog2(PRE_CYCLES) : 1;
  localparam logic [PCW-1:0]       PRE_LAST = PCW'(PRE_CYCLES - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

  typedef enum logic {S_PRE, S_EVAL} state_t;

  state_t           state, state_nxt;
  logic [PCW-1:0]   pre_cnt;
  logic             cap, drop;
  logic [WIDTH-1:0] inv;
  logic             err_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_PRE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_PRE:   if (cap)  state_nxt = S_EVAL;
      S_EVAL:  if (drop) state_nxt = S_PRE;
      default: state_nxt = S_PRE;
    endcase
  end

  // in_ready depends only on state and pre_cnt, never on in_valid.
  always_comb begin
    in_ready  = (state == S_PRE) && (pre_cnt == PRE_LAST);
    out_valid = (state == S_EVAL);
    cap       = in_ready & in_valid;
    drop      = out_valid & out_ready;
  end

  // Counter runs only in precharge; it restarts from zero on every return to PRE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                pre_cnt <= '0;
    else if (state != S_PRE || cap)         pre_cnt <= '0;
    else if (pre_cnt != PRE_LAST)           pre_cnt <= pre_cnt + PCW'(1);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    wddl_lane u_lane (
      .clk   (clk),
      .rst   (rst),
      .cap   (cap),
      .clr   (drop),
      .p_in  (d_p_in[i]),
      .n_in  (d_n_in[i]),
      .p_out (d_p_out[i]),
      .n_out (d_n_out[i]),
      .inv   (inv[i])
    );
  end

  assign err_hit = cap & (|inv);

  // A fresh error on the same edge as err_clr survives the clear and counts as one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_flag  <= 1'b0;
      err_count <= '0;
    end else if (err_hit) begin
      err_flag  <= 1'b1;
      if (err_clr)                  err_count <= ERR_CNT_W'(1);
      else if (err_count != ERR_MAX) err_count <= err_count + ERR_CNT_W'(1);
    end else if (err_clr) begin
      err_flag  <= 1'b0;
      err_count <= '0;
    end
  end
endmodule

// File: tb/tb_wddl_prech_reg.sv
// Directed bench for wddl_prech_reg: PRE_CYCLES=1 table, PRE_CYCLES=3 cadence, 2-bit counter saturation, async reset.

module tb_wddl_prech_reg;
  logic clk = 1'b0;
  logic rst;
  logic iv, orr, ec;
  logic [7:0] dp, dn;
  logic iv3, or3;

  logic ir1, ov1, ef1;
  logic [7:0] po1, no1, cnt1;
  logic ir_s, ov_s, ef_s;
  logic [7:0] po_s, no_s;
  logic [1:0] cnt_s;
  logic ir3, ov3, ef3;
  logic [7:0] po3, no3, cnt3;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  wddl_prech_reg #(.WIDTH(8), .PRE_CYCLES(1), .ERR_CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir1), .d_p_in(dp), .d_n_in(dn),
    .d_p_out(po1), .d_n_out(no1), .out_valid(ov1), .out_ready(orr),
    .err_clr(ec), .err_flag(ef1), .err_count(cnt1));

  wddl_prech_reg #(.WIDTH(8), .PRE_CYCLES(1), .ERR_CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir_s), .d_p_in(dp), .d_n_in(dn),
    .d_p_out(po_s), .d_n_out(no_s), .out_valid(ov_s), .out_ready(orr),
    .err_clr(ec), .err_flag(ef_s), .err_count(cnt_s));

  wddl_prech_reg #(.WIDTH(8), .PRE_CYCLES(3), .ERR_CNT_W(8)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .d_p_in(dp), .d_n_in(dn),
    .d_p_out(po3), .d_n_out(no3), .out_valid(ov3), .out_ready(or3),
    .err_clr(1'b0), .err_flag(ef3), .err_count(cnt3));

  // ir is sampled before the edge; ov/p/n/f/cnt after it.
  typedef struct {
    logic       v;
    logic [7:0] dp, dn;
    logic       r, c;
    logic       ir, ov;
    logic [7:0] p, n;
    logic       f;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial begin
    //           v  dp     dn     r  c  ir ov p      n      f  cnt
    tbl[0]  = '{1, 8'hA5, 8'h5A, 1, 0, 1, 1, 8'hA5, 8'h5A, 0, 0};
    tbl[1]  = '{1, 8'h3C, 8'hC3, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0};
    tbl[2]  = '{1, 8'h3C, 8'hC3, 1, 0, 1, 1, 8'h3C, 8'hC3, 0, 0};
    tbl[3]  = '{0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0};
    tbl[4]  = '{1, 8'hFF, 8'h0F, 0, 0, 1, 1, 8'hF0, 8'h00, 1, 1};
    tbl[5]  = '{1, 8'hA5, 8'h5A, 0, 0, 0, 1, 8'hF0, 8'h00, 1, 1};
    tbl[6]  = '{1, 8'hA5, 8'h5A, 0, 0, 0, 1, 8'hF0, 8'h00, 1, 1};
    tbl[7]  = '{1, 8'hA5, 8'h5A, 0, 0, 0, 1, 8'hF0, 8'h00, 1, 1};
    tbl[8]  = '{1, 8'hA5, 8'h5A, 0, 0, 0, 1, 8'hF0, 8'h00, 1, 1};
    tbl[9]  = '{1, 8'hA5, 8'h5A, 0, 0, 0, 1, 8'hF0, 8'h00, 1, 1};
    tbl[10] = '{0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 1, 1};
    tbl[11] = '{1, 8'h00, 8'h00, 1, 1, 1, 1, 8'h00, 8'h00, 1, 1};
    tbl[12] = '{0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 1, 1};
    tbl[13] = '{0, 8'h00, 8'h00, 1, 1, 1, 0, 8'h00, 8'h00, 0, 0};
    tbl[14] = '{1, 8'hFF, 8'hFF, 1, 0, 1, 1, 8'h00, 8'h00, 1, 1};
    tbl[15] = '{0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 1, 1};
    tbl[16] = '{1, 8'h01, 8'h00, 1, 0, 1, 1, 8'h01, 8'h00, 1, 2};
    tbl[17] = '{0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 1, 2};
    tbl[18] = '{1, 8'h0F, 8'hF0, 1, 0, 1, 1, 8'h0F, 8'hF0, 1, 2};
    tbl[19] = '{0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 1, 2};

    rst = 1'b1; iv = 1'b0; orr = 1'b0; ec = 1'b0; dp = 8'h00; dn = 8'h00;
    iv3 = 1'b0; or3 = 1'b0;
    #2;
    chk("rst p_out", po1, 8'h00);
    chk("rst n_out", no1, 8'h00);
    chk("rst out_valid", ov1, 1'b0);
    chk("rst err_flag", ef1, 1'b0);
    chk("rst err_count", cnt1, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      iv = tbl[i].v; dp = tbl[i].dp; dn = tbl[i].dn; orr = tbl[i].r; ec = tbl[i].c;
      #1;
      chk($sformatf("v%0d in_ready", i), ir1, tbl[i].ir);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), ov1, tbl[i].ov);
      chk($sformatf("v%0d p_out", i), po1, tbl[i].p);
      chk($sformatf("v%0d n_out", i), no1, tbl[i].n);
      chk($sformatf("v%0d err_flag", i), ef1, tbl[i].f);
      chk($sformatf("v%0d err_count", i), cnt1, tbl[i].cnt);
      chk($sformatf("v%0d err_count_w2", i), cnt_s, tbl[i].cnt);
      @(negedge clk);
    end

    // Clear, then five invalid words: the 2-bit counter must stick at 3.
    iv = 1'b0; orr = 1'b1; ec = 1'b1;
    @(negedge clk);
    ec = 1'b0;
    chk("clr err_count", cnt1, 8'h00);
    chk("clr err_flag_w2", ef_s, 1'b0);
    for (int k = 0; k < 5; k++) begin
      iv = 1'b1; dp = 8'hFF; dn = 8'hFF;
      @(negedge clk);
      iv = 1'b0;
      @(negedge clk);
      if (k == 2) chk("sat w2 after 3", cnt_s, 2'd3);
    end
    chk("sat err_count_w2", cnt_s, 2'd3);
    chk("sat err_flag_w2", ef_s, 1'b1);
    chk("sat err_count_w8", cnt1, 8'd5);

    // Async reset while holding a word in EVAL.
    iv = 1'b1; dp = 8'hA5; dn = 8'h5A; orr = 1'b0;
    @(posedge clk);
    #1;
    chk("eval before rst ov", ov1, 1'b1);
    chk("eval before rst p", po1, 8'hA5);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst p_out", po1, 8'h00);
    chk("async rst n_out", no1, 8'h00);
    chk("async rst out_valid", ov1, 1'b0);
    chk("async rst err_count", cnt1, 8'h00);
    chk("async rst err_count_w2", cnt_s, 2'd0);

    // PRE_CYCLES=3 cadence with in_valid and out_ready held high.
    iv = 1'b0; orr = 1'b1;
    iv3 = 1'b1; or3 = 1'b1; dp = 8'hA5; dn = 8'h5A;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      logic exp_ir, exp_ov;
      exp_ir = (k % 4) == 2;
      exp_ov = (k % 4) == 3;
      #1;
      chk($sformatf("pre3 c%0d in_ready", k), ir3, exp_ir);
      chk($sformatf("pre3 c%0d out_valid", k), ov3, exp_ov);
      chk($sformatf("pre3 c%0d p_out", k), po3, exp_ov ? 8'hA5 : 8'h00);
      chk($sformatf("pre3 c%0d n_out", k), no3, exp_ov ? 8'h5A : 8'h00);
      @(negedge clk);
    end
    chk("pre3 err_flag", ef3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
